// File: rtl/pc_sp_sequencer_if.sv
// Command, status and data-memory signals of the PC/SP sequencer.
// master: controller + memory side (drives commands, ack, read data).
// slave : sequencer side (drives pc/sp, memory request, status).
interface pc_sp_sequencer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] push_data;
  logic              flag_zero;
  logic              flag_neg;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] sp;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              halted;
  logic              stack_err;
  logic              bus_err;

  modport master (
    output cmd_valid, cmd_op, target, push_data, flag_zero, flag_neg, resume,
           mem_ack, mem_rdata,
    input  cmd_ready, pc, sp, mem_req, mem_we, mem_addr, mem_wdata,
           pop_data, pop_valid, halted, stack_err, bus_err
  );

  modport slave (
    input  cmd_valid, cmd_op, target, push_data, flag_zero, flag_neg, resume,
           mem_ack, mem_rdata,
    output cmd_ready, pc, sp, mem_req, mem_we, mem_addr, mem_wdata,
           pop_data, pop_valid, halted, stack_err, bus_err
  );
endinterface

// File: rtl/pc_sp_sequencer.sv
// Program-counter / hardware-stack sequencer with a req/ack data-memory port.
// Ports: clk, reset (async, active-high), bus (pc_sp_sequencer_if.slave):
//   command in (cmd_*, target, push_data, flags, resume), pc/sp out,
//   memory request out / ack + rdata in, pop result and status out.
module pc_sp_sequencer #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(10'h3FE),
  parameter logic [ADDR_W-1:0] SP_MIN   = ADDR_W'(10'h200),
  parameter int unsigned       WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  pc_sp_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JLT  = 4'd2;
  localparam logic [3:0] OP_JEQ  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_PUSH = 4'd6;
  localparam logic [3:0] OP_POP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  typedef enum logic [1:0] {ST_RUN, ST_MEM, ST_HALTED, ST_FAULT} state_e;

  state_e            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_pc,        w_pc_nxt;
  logic [ADDR_W-1:0] r_sp,        w_sp_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]        r_op,        w_op_nxt;
  logic [ADDR_W-1:0] r_target,    w_target_nxt;
  logic [CNT_W-1:0]  r_wait_cnt,  w_wait_cnt_nxt;
  logic [DATA_W-1:0] r_pop_data,  w_pop_data_nxt;
  logic              r_pop_valid, w_pop_valid_nxt;
  logic              r_halted,    w_halted_nxt;
  logic              r_stack_err, w_stack_err_nxt;
  logic              r_bus_err,   w_bus_err_nxt;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_sp_inc;
  logic [ADDR_W-1:0] w_sp_dec;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_sp_inc = r_sp + ADDR_W'(1);
  assign w_sp_dec = r_sp - ADDR_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= '0;
      r_sp        <= SP_INIT;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_op        <= '0;
      r_target    <= '0;
      r_wait_cnt  <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_stack_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_sp        <= w_sp_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_op        <= w_op_nxt;
      r_target    <= w_target_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_pop_data  <= w_pop_data_nxt;
      r_pop_valid <= w_pop_valid_nxt;
      r_halted    <= w_halted_nxt;
      r_stack_err <= w_stack_err_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_sp_nxt        = r_sp;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_op_nxt        = r_op;
    w_target_nxt    = r_target;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_pop_data_nxt  = r_pop_data;
    w_pop_valid_nxt = 1'b0;
    w_stack_err_nxt = r_stack_err;
    w_bus_err_nxt   = r_bus_err;

    case (r_state)
      ST_RUN: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_JMP:  w_pc_nxt = bus.target;
            OP_JLT:  w_pc_nxt = bus.flag_neg  ? bus.target : w_pc_inc;
            OP_JEQ:  w_pc_nxt = bus.flag_zero ? bus.target : w_pc_inc;
            OP_HALT: w_state_nxt = ST_HALTED;
            OP_CALL, OP_PUSH: begin
              if (r_sp == SP_MIN) begin
                w_state_nxt     = ST_FAULT;
                w_stack_err_nxt = 1'b1;
              end else begin
                w_state_nxt     = ST_MEM;
                w_mem_req_nxt   = 1'b1;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = r_sp;
                w_mem_wdata_nxt = (bus.cmd_op == OP_CALL) ? DATA_W'(w_pc_inc)
                                                          : bus.push_data;
                w_op_nxt        = bus.cmd_op;
                w_target_nxt    = bus.target;
                w_wait_cnt_nxt  = '0;
              end
            end
            OP_RET, OP_POP: begin
              if (r_sp == SP_INIT) begin
                w_state_nxt     = ST_FAULT;
                w_stack_err_nxt = 1'b1;
              end else begin
                w_state_nxt     = ST_MEM;
                w_mem_req_nxt   = 1'b1;
                w_mem_we_nxt    = 1'b0;
                w_mem_addr_nxt  = w_sp_inc;
                w_mem_wdata_nxt = '0;
                w_op_nxt        = bus.cmd_op;
                w_target_nxt    = bus.target;
                w_wait_cnt_nxt  = '0;
              end
            end
            default: w_pc_nxt = w_pc_inc;  // NEXT and unused encodings
          endcase
        end
      end

      ST_MEM: begin
        if (bus.mem_ack) begin
          w_state_nxt   = ST_RUN;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          case (r_op)
            OP_CALL: begin
              w_sp_nxt = w_sp_dec;
              w_pc_nxt = r_target;
            end
            OP_PUSH: begin
              w_sp_nxt = w_sp_dec;
              w_pc_nxt = w_pc_inc;
            end
            OP_RET: begin
              w_sp_nxt = w_sp_inc;
              w_pc_nxt = bus.mem_rdata[ADDR_W-1:0];
            end
            default: begin  // POP
              w_sp_nxt        = w_sp_inc;
              w_pc_nxt        = w_pc_inc;
              w_pop_data_nxt  = bus.mem_rdata;
              w_pop_valid_nxt = 1'b1;
            end
          endcase
        end else if (r_wait_cnt == CNT_W'(WAIT_MAX)) begin
          // Wait budget exhausted: abandon the transaction.
          w_state_nxt   = ST_FAULT;
          w_bus_err_nxt = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      ST_HALTED: begin
        if (bus.resume) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = w_pc_inc;
        end
      end

      default: ;  // ST_FAULT holds until reset
    endcase

    w_halted_nxt = (w_state_nxt == ST_HALTED);
  end

  assign bus.cmd_ready = (r_state == ST_RUN);
  assign bus.pc        = r_pc;
  assign bus.sp        = r_sp;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.halted    = r_halted;
  assign bus.stack_err = r_stack_err;
  assign bus.bus_err   = r_bus_err;

endmodule

// File: tb/tb_pc_sp_sequencer.sv
// Directed bench for pc_sp_sequencer: a vector table for the single-cycle
// flow commands plus hand-written sequences for memory, halt and fault cases.
module tb_pc_sp_sequencer;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WAIT_MAX = 15;

  localparam logic [3:0] OP_NEXT = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JLT  = 4'd2;
  localparam logic [3:0] OP_JEQ  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_PUSH = 4'd6;
  localparam logic [3:0] OP_POP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  logic clk;
  logic reset;

  pc_sp_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pc_sp_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SP_INIT (10'h3FE),
    .SP_MIN  (10'h200),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [9:0]  tgt;
    logic        fz;
    logic        fn;
    logic [9:0]  exp_pc;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NEXT;
    bus.target    = '0;
    bus.push_data = '0;
    bus.flag_zero = 1'b0;
    bus.flag_neg  = 1'b0;
    bus.resume    = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [9:0] tgt, input logic [15:0] pd);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.target    = tgt;
    bus.push_data = pd;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Memory command with ack after 'dly' wait cycles.
  task automatic mem_cmd(input logic [3:0] op, input logic [9:0] tgt,
                         input logic [15:0] pd, input logic [15:0] rd, input int dly);
    issue(op, tgt, pd);
    for (int k = 0; k < dly; k++) step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    int n;

    vec[0]  = '{1'b1, OP_NEXT, 10'h000, 1'b0, 1'b0, 10'h001};
    vec[1]  = '{1'b1, OP_NEXT, 10'h000, 1'b0, 1'b0, 10'h002};
    vec[2]  = '{1'b1, OP_NEXT, 10'h000, 1'b0, 1'b0, 10'h003};
    vec[3]  = '{1'b1, OP_JMP,  10'h050, 1'b0, 1'b0, 10'h050};
    vec[4]  = '{1'b0, OP_JMP,  10'h123, 1'b0, 1'b0, 10'h050};
    vec[5]  = '{1'b1, OP_JMP,  10'h010, 1'b0, 1'b0, 10'h010};
    vec[6]  = '{1'b1, OP_JEQ,  10'h100, 1'b0, 1'b0, 10'h011};
    vec[7]  = '{1'b1, OP_JEQ,  10'h100, 1'b1, 1'b0, 10'h100};
    vec[8]  = '{1'b1, OP_JLT,  10'h200, 1'b1, 1'b0, 10'h101};
    vec[9]  = '{1'b1, OP_JLT,  10'h200, 1'b0, 1'b1, 10'h200};
    vec[10] = '{1'b1, OP_JEQ,  10'h300, 1'b0, 1'b1, 10'h201};
    vec[11] = '{1'b1, 4'd9,    10'h3FF, 1'b1, 1'b1, 10'h202};
    vec[12] = '{1'b1, 4'd15,   10'h3FF, 1'b1, 1'b1, 10'h203};
    vec[13] = '{1'b1, OP_JMP,  10'h3FF, 1'b0, 1'b0, 10'h3FF};
    vec[14] = '{1'b1, OP_NEXT, 10'h000, 1'b0, 1'b0, 10'h000};
    vec[15] = '{1'b1, OP_JMP,  10'h020, 1'b0, 1'b0, 10'h020};

    // Reset values
    do_reset();
    chk("rst pc",        32'(bus.pc),        32'h000);
    chk("rst sp",        32'(bus.sp),        32'h3FE);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst mem_req",   32'(bus.mem_req),   32'h0);
    chk("rst mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst pop_valid", 32'(bus.pop_valid), 32'h0);
    chk("rst status",    32'({bus.halted, bus.stack_err, bus.bus_err}), 32'h0);

    // Single-cycle flow commands; ack held high to show it is ignored in RUN
    bus.mem_ack = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.cmd_valid = vec[i].valid;
      bus.cmd_op    = vec[i].op;
      bus.target    = vec[i].tgt;
      bus.flag_zero = vec[i].fz;
      bus.flag_neg  = vec[i].fn;
      step();
      chk($sformatf("vec%0d pc", i),      32'(bus.pc),      32'(vec[i].exp_pc));
      chk($sformatf("vec%0d sp", i),      32'(bus.sp),      32'h3FE);
      chk($sformatf("vec%0d mem_req", i), 32'(bus.mem_req), 32'h0);
    end
    bus.cmd_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.flag_zero = 1'b0;
    bus.flag_neg  = 1'b0;

    // CALL at pc 0x020 with ack in the first MEM cycle
    issue(OP_CALL, 10'h080, 16'h0000);
    chk("call mem_req",   32'(bus.mem_req),   32'h1);
    chk("call mem_we",    32'(bus.mem_we),    32'h1);
    chk("call mem_addr",  32'(bus.mem_addr),  32'h3FE);
    chk("call mem_wdata", 32'(bus.mem_wdata), 32'h0021);
    chk("call cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("call pc hold",   32'(bus.pc),        32'h020);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("call done pc",      32'(bus.pc),        32'h080);
    chk("call done sp",      32'(bus.sp),        32'h3FD);
    chk("call done mem_req", 32'(bus.mem_req),   32'h0);
    chk("call done ready",   32'(bus.cmd_ready), 32'h1);

    // RET with ack delayed three cycles
    issue(OP_RET, 10'h000, 16'h0000);
    n = 1;
    chk("ret mem_we",   32'(bus.mem_we),   32'h0);
    chk("ret mem_addr", 32'(bus.mem_addr), 32'h3FE);
    for (int k = 0; k < 3; k++) begin
      step();
      n++;
      chk($sformatf("ret wait%0d mem_req", k), 32'(bus.mem_req), 32'h1);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h0021;
    step();
    n++;
    bus.mem_ack   = 1'b0;
    chk("ret pc",     32'(bus.pc),        32'h021);
    chk("ret sp",     32'(bus.sp),        32'h3FE);
    chk("ret ready",  32'(bus.cmd_ready), 32'h1);
    chk("ret cycles", 32'(n),             32'd5);

    // PUSH then POP round trip
    mem_cmd(OP_PUSH, 10'h000, 16'hBEEF, 16'h0000, 0);
    chk("push pc", 32'(bus.pc), 32'h022);
    chk("push sp", 32'(bus.sp), 32'h3FD);
    issue(OP_POP, 10'h000, 16'h0000);
    chk("pop mem_addr", 32'(bus.mem_addr), 32'h3FE);
    chk("pop pv early", 32'(bus.pop_valid), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    step();
    bus.mem_ack   = 1'b0;
    chk("pop pop_valid", 32'(bus.pop_valid), 32'h1);
    chk("pop pop_data",  32'(bus.pop_data),  32'hBEEF);
    chk("pop sp",        32'(bus.sp),        32'h3FE);
    chk("pop pc",        32'(bus.pc),        32'h023);
    step();
    chk("pop pulse end", 32'(bus.pop_valid), 32'h0);

    // HALT at 0x030, commands ignored, then resume
    issue(OP_JMP, 10'h030, 16'h0000);
    issue(OP_HALT, 10'h000, 16'h0000);
    chk("halt halted", 32'(bus.halted),    32'h1);
    chk("halt ready",  32'(bus.cmd_ready), 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_JMP;
    bus.target    = 10'h111;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("halt c%0d pc", k), 32'({bus.halted, bus.pc}), 32'({1'b1, 10'h030}));
    end
    bus.cmd_valid = 1'b0;
    bus.resume    = 1'b1;
    step();
    bus.resume    = 1'b0;
    chk("resume pc",     32'(bus.pc),     32'h031);
    chk("resume halted", 32'(bus.halted), 32'h0);

    // Underflow: POP on empty stack
    do_reset();
    issue(OP_POP, 10'h000, 16'h0000);
    chk("uflow stack_err", 32'(bus.stack_err), 32'h1);
    chk("uflow mem_req",   32'(bus.mem_req),   32'h0);
    chk("uflow ready",     32'(bus.cmd_ready), 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_NEXT;
    repeat (3) step();
    bus.cmd_valid = 1'b0;
    chk("uflow pc",      32'(bus.pc),        32'h000);
    chk("uflow sp",      32'(bus.sp),        32'h3FE);
    chk("uflow absorb",  32'({bus.cmd_ready, bus.mem_req, bus.stack_err}), 32'h1);

    // Overflow: fill stack down to SP_MIN, then one more PUSH
    do_reset();
    for (int k = 0; k < 510; k++) mem_cmd(OP_PUSH, 10'h000, 16'(k), 16'h0000, 0);
    chk("oflow fill sp", 32'(bus.sp), 32'h200);
    chk("oflow fill pc", 32'(bus.pc), 32'h1FE);
    issue(OP_PUSH, 10'h000, 16'h5555);
    chk("oflow stack_err", 32'(bus.stack_err), 32'h1);
    chk("oflow mem_req",   32'(bus.mem_req),   32'h0);
    chk("oflow sp",        32'(bus.sp),        32'h200);
    chk("oflow pc",        32'(bus.pc),        32'h1FE);

    // Bus timeout: PUSH that is never acked
    do_reset();
    issue(OP_PUSH, 10'h000, 16'h1234);
    n = 0;
    while (bus.mem_req && n < 100) begin
      n++;
      step();
    end
    chk("tmo req cycles", 32'(n),             32'(WAIT_MAX + 1));
    chk("tmo bus_err",    32'(bus.bus_err),   32'h1);
    chk("tmo mem_req",    32'(bus.mem_req),   32'h0);
    chk("tmo ready",      32'(bus.cmd_ready), 32'h0);
    chk("tmo sp",         32'(bus.sp),        32'h3FE);
    chk("tmo pc",         32'(bus.pc),        32'h000);

    // Asynchronous reset drops mem_req mid-cycle
    do_reset();
    issue(OP_PUSH, 10'h000, 16'h4321);
    chk("arst pre mem_req", 32'(bus.mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst mem_req", 32'(bus.mem_req), 32'h0);
    chk("arst sp",      32'(bus.sp),      32'h3FE);
    #2 reset = 1'b0;
    step();
    chk("arst ready", 32'(bus.cmd_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
